plot_buffer: RTL and testbench

PLOT_BUFFER -- requirements
Module: plot_buffer

---
 rtl/plot_buffer.sv | 132 +++++++++++++
 tb/tb_plot_buffer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_buffer.sv
// plot_buffer
// -----------
// Small FIFO that sits between a drawing engine and a VGA adapter. Pixel
// requests from the engine are queued and then issued to the adapter as
// single-cycle write strobes, one per clock, whenever hold is low.
//
// Optional feature (macro PLOT_BUFFER_CLIP_EN):
//   defined   - pixels outside 0..159 / 0..119 are discarded on acceptance
//               and counted in drop_count (saturating at 0xFFFF).
//   undefined - every accepted pixel is queued with in_x[7:0] / in_y[6:0],
//               and drop_count is tied to 0.
//
// Parameters:
//   DEPTH      FIFO entry count, power of two from 2 to 64 (default 8)
//
// Ports:
//   clk        system clock (50 MHz)
//   rst        synchronous active-high reset
//   in_x       signed 9-bit pixel x from the drawing engine
//   in_y       signed 8-bit pixel y
//   in_colour  3-bit pixel colour
//   in_valid   a pixel request is present
//   in_ready   request can be accepted this cycle (FIFO not full)
//   hold       while high, no pixel is issued to the adapter
//   vga_x      x to the adapter (0..159)
//   vga_y      y to the adapter (0..119)
//   vga_colour colour to the adapter
//   vga_plot   single-cycle write strobe to the adapter
//   drop_count number of clipped pixels
//   idle       FIFO empty and no strobe in flight

module plot_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  in_x,
  input  logic [7:0]  in_y,
  input  logic [2:0]  in_colour,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        hold,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic [15:0] drop_count,
  output logic        idle
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [17:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic        accept;
  logic        in_range;
  logic        push;
  logic        pop;
  logic [17:0] in_word;

  // Ready depends only on occupancy (and reset), so a same-cycle pop never
  // lets a new pixel push through a full FIFO.
  assign in_ready = ~rst & (count != FULL);
  assign accept   = in_valid & in_ready;
  assign pop      = ~hold & (count != '0);
  assign push     = accept & in_range;
  assign in_word  = {in_x[7:0], in_y[6:0], in_colour};
  assign idle     = rst | ((count == '0) & ~vga_plot);

`ifdef PLOT_BUFFER_CLIP_EN
  // Sign bit clear plus an upper-bound test gives the signed range check.
  assign in_range = ~in_x[8] & (in_x[7:0] <= 8'd159) &
                    ~in_y[7] & (in_y[6:0] <= 7'd119);

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (accept && !in_range && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  logic unused_sign_bits;

  assign in_range         = 1'b1;
  assign drop_count       = '0;
  assign unused_sign_bits = in_x[8] ^ in_y[7];
`endif

  // Storage is left unreset so it can map onto distributed RAM; the
  // pointers and occupancy alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop) begin
        {vga_x, vga_y, vga_colour} <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
        vga_plot <= 1'b1;
      end else begin
        vga_plot <= 1'b0;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_buffer.sv
// Self-checking bench for plot_buffer. A queue-based reference model tracks
// the pixels waiting in the buffer, the clipped-pixel count and the values
// last presented to the adapter; every clock the DUT outputs are compared
// against it, alongside directed checks for the main scenarios.

module tb_plot_buffer;

  localparam int DEPTH = 8;

`ifdef PLOT_BUFFER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [8:0]  in_x;
  logic [7:0]  in_y;
  logic [2:0]  in_colour;
  logic        in_valid;
  logic        in_ready;
  logic        hold;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic [15:0] drop_count;
  logic        idle;

  plot_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .hold       (hold),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .drop_count (drop_count),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [17:0] mq[$];
  int          modelDrops;
  logic [7:0]  expX;
  logic [6:0]  expY;
  logic [2:0]  expC;
  bit          expPlot;

  int passed;
  int failed;
  int total;
  int plotSeen;

  function automatic bit inRange(input logic [8:0] x, input logic [7:0] y);
    int sx;
    int sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    return (sx >= 0) && (sx <= 159) && (sy >= 0) && (sy <= 119);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) begin
      passed++;
    end else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [8:0] x,
                               input logic [7:0] y, input logic [2:0] c,
                               input logic h, input logic r);
    in_valid  = v;
    in_x      = x;
    in_y      = y;
    in_colour = c;
    hold      = h;
    rst       = r;
    #1;
  endtask

  // One clock: check ready before the edge, advance the model across the
  // edge, then compare every output against the model.
  task automatic tick();
    bit          expReady;
    bit          accepted;
    bit          expIdle;
    logic [17:0] w;
    expReady = !rst && (mq.size() < DEPTH);
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, expReady});
    accepted = expReady && (in_valid === 1'b1);
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      modelDrops = 0;
      expPlot    = 1'b0;
      expX       = '0;
      expY       = '0;
      expC       = '0;
    end else begin
      if (!hold && mq.size() > 0) begin
        w = mq.pop_front();
        {expX, expY, expC} = w;
        expPlot = 1'b1;
      end else begin
        expPlot = 1'b0;
      end
      if (accepted) begin
        if (CLIP && !inRange(in_x, in_y)) begin
          if (modelDrops < 65535) modelDrops++;
        end else begin
          mq.push_back({in_x[7:0], in_y[6:0], in_colour});
        end
      end
    end
    if (vga_plot === 1'b1) plotSeen++;
    expIdle = rst || (mq.size() == 0 && !expPlot);
    checkOutput("vga_plot",   {31'b0, vga_plot},   {31'b0, expPlot});
    checkOutput("vga_x",      {24'b0, vga_x},      {24'b0, expX});
    checkOutput("vga_y",      {25'b0, vga_y},      {25'b0, expY});
    checkOutput("vga_colour", {29'b0, vga_colour}, {29'b0, expC});
    checkOutput("drop_count", {16'b0, drop_count}, 32'(modelDrops));
    checkOutput("idle",       {31'b0, idle},       {31'b0, expIdle});
  endtask

  initial begin
    int startSeen;
    logic [8:0] rx;
    logic [7:0] ry;

    passed     = 0;
    failed     = 0;
    total      = 0;
    plotSeen   = 0;
    modelDrops = 0;
    expPlot    = 1'b0;
    expX       = '0;
    expY       = '0;
    expC       = '0;

    // Reset
    applyStimulus(1'b0, 9'd0, 8'd0, 3'd0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("reset_idle", {31'b0, idle}, 32'd1);
    checkOutput("reset_ready_low", {31'b0, in_ready}, 32'd0);
    applyStimulus(1'b0, 9'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    checkOutput("ready_after_reset", {31'b0, in_ready}, 32'd1);

    // Single pixel latency
    applyStimulus(1'b1, 9'd5, 8'd7, 3'd3, 1'b0, 1'b0);
    tick();
    checkOutput("single_no_plot_yet", {31'b0, vga_plot}, 32'd0);
    applyStimulus(1'b0, 9'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    tick();
    checkOutput("single_plot", {31'b0, vga_plot}, 32'd1);
    checkOutput("single_x", {24'b0, vga_x}, 32'd5);
    checkOutput("single_y", {25'b0, vga_y}, 32'd7);
    checkOutput("single_colour", {29'b0, vga_colour}, 32'd3);
    tick();
    checkOutput("single_plot_done", {31'b0, vga_plot}, 32'd0);
    checkOutput("single_idle", {31'b0, idle}, 32'd1);

    // Fill under hold, then drain in order
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 9'($urandom_range(0, 159)), 8'($urandom_range(0, 119)),
                    3'($urandom_range(0, 7)), 1'b1, 1'b0);
      tick();
    end
    checkOutput("full_ready_low", {31'b0, in_ready}, 32'd0);
    applyStimulus(1'b1, 9'd42, 8'd42, 3'd7, 1'b1, 1'b0);
    tick();
    startSeen = plotSeen;
    applyStimulus(1'b0, 9'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      checkOutput("drain_plot", {31'b0, vga_plot}, 32'd1);
    end
    tick();
    checkOutput("drain_count", 32'(plotSeen - startSeen), 32'(DEPTH));
    checkOutput("drain_idle", {31'b0, idle}, 32'd1);

    // Clipping boundaries
    startSeen = plotSeen;
    applyStimulus(1'b1, 9'h1FF, 8'd10, 3'd1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 9'd160, 8'd10, 3'd2, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 9'd10, 8'd120, 3'd4, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 9'd159, 8'd119, 3'd5, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 9'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("clip_strobes", 32'(plotSeen - startSeen), CLIP ? 32'd1 : 32'd4);
    checkOutput("clip_drops", {16'b0, drop_count}, CLIP ? 32'd3 : 32'd0);
    checkOutput("clip_last_x", {24'b0, vga_x}, 32'd159);
    checkOutput("clip_last_y", {25'b0, vga_y}, 32'd119);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rx = 9'(int'($urandom_range(0, 199)) - 20);
      ry = 8'(int'($urandom_range(0, 149)) - 15);
      applyStimulus($urandom_range(0, 3) != 0, rx, ry, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 3) == 0, 1'b0);
      tick();
    end

    // Reset with entries queued
    applyStimulus(1'b0, 9'd0, 8'd0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 9'($urandom_range(0, 159)), 8'($urandom_range(0, 119)),
                    3'($urandom_range(0, 7)), 1'b1, 1'b0);
      tick();
    end
    startSeen = plotSeen;
    applyStimulus(1'b0, 9'd0, 8'd0, 3'd0, 1'b0, 1'b1);
    tick();
    checkOutput("rst_no_plot", {31'b0, vga_plot}, 32'd0);
    checkOutput("rst_idle", {31'b0, idle}, 32'd1);
    applyStimulus(1'b0, 9'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    checkOutput("rst_ready_after", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_drops", {16'b0, drop_count}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("rst_discarded", 32'(plotSeen - startSeen), 32'd0);
    checkOutput("rst_idle_after", {31'b0, idle}, 32'd1);

    // Full-screen streaming fill
    startSeen = plotSeen;
    for (int i = 0; i < 160 * 120; i++) begin
      applyStimulus(1'b1, 9'(i % 160), 8'(i / 160), 3'(i % 8), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 9'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    tick();
    checkOutput("stream_strobes", 32'(plotSeen - startSeen), 32'd19200);
    checkOutput("stream_last_x", {24'b0, vga_x}, 32'd159);
    checkOutput("stream_last_y", {25'b0, vga_y}, 32'd119);
    tick();
    checkOutput("stream_idle", {31'b0, idle}, 32'd1);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
